// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   N-master to 1-slave Wishbone-classic arbiter that sits in front of a
//   mem_byte instance. The grant is registered, and the owning master keeps
//   the bus for as long as it holds cyc. Arbitration uses either fixed
//   priority or round-robin. A slave that stops acknowledging is cut off by
//   an ack timeout, and the owning master receives a one-cycle error.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   m_cyc_i/stb_i/we_i, m_adr_i, m_dat_i, m_funct3_i
//                    per-master request side; vectors are packed, with
//                    master k at [k*W +: W]
//   m_dat_o          slave read data, broadcast to every master
//   m_ack_o, m_err_o per-master ack / timeout error (granted master only)
//   m_stall_o        master is requesting but does not own the bus
//   s_*              single slave port; follows the granted master
//   o_grant          registered one-hot grant; all zero when idle
module mem_port_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int RR_MODE        = 0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS*3-1:0]          m_funct3_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [NUM_MASTERS-1:0]            m_stall_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  output logic [2:0]                        s_funct3_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i,
  output logic [NUM_MASTERS-1:0]            o_grant
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_ERROR} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic                   out_en_q, out_en_d;

  logic [NUM_MASTERS-1:0] req;
  logic [PW-1:0]          win_idx;
  logic                   win_vld;
  logic [PW-1:0]          cand;

  logic                   g_cyc, g_stb, g_we;
  logic [ADDR_WIDTH-1:0]  g_adr;
  logic [DATA_WIDTH-1:0]  g_dat;
  logic [2:0]             g_f3;
  logic                   active;

  assign req = m_cyc_i & m_stb_i;

  // Winner selection. Round-robin scans upward from the master after the
  // last winner, so the previous owner is considered last.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    if (RR_MODE != 0) begin
      for (int i = 1; i <= NUM_MASTERS; i++) begin
        cand = PW'((int'(rr_ptr_q) + i) % NUM_MASTERS);
        if (!win_vld && req[cand]) begin
          win_vld = 1'b1;
          win_idx = cand;
        end
      end
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!win_vld && req[i]) begin
          win_vld = 1'b1;
          win_idx = PW'(i);
        end
      end
    end
  end

  // The grant is one-hot, so an OR across masters selects the owner's fields.
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_adr = '0;
    g_dat = '0;
    g_f3  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        g_cyc = g_cyc | m_cyc_i[k];
        g_stb = g_stb | m_stb_i[k];
        g_we  = g_we  | m_we_i[k];
        g_adr = g_adr | m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        g_dat = g_dat | m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
        g_f3  = g_f3  | m_funct3_i[k*3 +: 3];
      end
    end
  end

  assign active     = (state_q == ST_ACTIVE);
  assign s_cyc_o    = active & g_cyc;
  assign s_stb_o    = active & g_cyc & g_stb;
  assign s_we_o     = active & g_we;
  assign s_adr_o    = active ? g_adr : '0;
  assign s_dat_o    = active ? g_dat : '0;
  assign s_funct3_o = active ? g_f3  : '0;
  assign m_dat_o    = s_dat_i;
  assign m_ack_o    = active ? (grant_q & {NUM_MASTERS{s_ack_i}}) : '0;
  assign m_err_o    = (state_q == ST_ERROR) ? grant_q : '0;
  // Stall is held low for the first cycle after reset as well as during it.
  assign m_stall_o  = out_en_q ? (req & ~grant_q) : '0;
  assign o_grant    = grant_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    tmo_cnt_d = tmo_cnt_q;
    out_en_d  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        tmo_cnt_d = '0;
        if (win_vld) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          rr_ptr_d         = win_idx;
          state_d          = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (!g_cyc) begin
          // Owner released the bus; re-arbitrate from IDLE next cycle.
          grant_d   = '0;
          tmo_cnt_d = '0;
          state_d   = ST_IDLE;
        end else if (g_stb && !s_ack_i && (TIMEOUT_CYCLES != 0)) begin
          // A same-cycle ack bypasses this branch, so an ack always beats the timeout.
          if (tmo_cnt_q == TMO_LAST) begin
            tmo_cnt_d = '0;
            state_d   = ST_ERROR;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
          end
        end else begin
          tmo_cnt_d = '0;
        end
      end
      ST_ERROR: begin
        grant_d   = '0;
        tmo_cnt_d = '0;
        state_d   = ST_IDLE;
      end
      default: begin
        grant_d   = '0;
        tmo_cnt_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= PW'(NUM_MASTERS - 1);
      tmo_cnt_q <= '0;
      out_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      tmo_cnt_q <= tmo_cnt_d;
      out_en_q  <= out_en_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;

  int vecs  = 0;
  int fails = 0;

  // Instance A: 2 masters, fixed priority, timeout 16
  logic [1:0]  a_cyc = '0, a_stb = '0, a_we = '0;
  logic [31:0] a_adr = '0;
  logic [63:0] a_dat = '0;
  logic [5:0]  a_f3  = '0;
  logic [31:0] a_mdat;
  logic [1:0]  a_ack, a_err, a_stall, a_grant;
  logic        a_scyc, a_sstb, a_swe;
  logic [15:0] a_sadr;
  logic [31:0] a_sdat;
  logic [2:0]  a_sf3;
  logic [31:0] a_srdat;
  logic        a_sack;
  logic        ack_en = 1'b1;
  logic [31:0] mem [16];

  // Instance B: 4 masters, round-robin
  logic [3:0]   b_cyc = '0, b_stb = '0, b_we = '0;
  logic [63:0]  b_adr = '0;
  logic [127:0] b_dat = '0;
  logic [11:0]  b_f3  = '0;
  logic [31:0]  b_mdat;
  logic [3:0]   b_ack, b_err, b_stall, b_grant;
  logic         b_scyc, b_sstb, b_swe;
  logic [15:0]  b_sadr;
  logic [31:0]  b_sdat;
  logic [2:0]   b_sf3;
  logic [31:0]  b_srdat;
  logic         b_sack;

  assign b_srdat = 32'h0;

  mem_port_arbiter #(.NUM_MASTERS(2), .DATA_WIDTH(32), .ADDR_WIDTH(16),
                     .RR_MODE(0), .TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .rst(rst),
    .m_cyc_i(a_cyc), .m_stb_i(a_stb), .m_we_i(a_we), .m_adr_i(a_adr),
    .m_dat_i(a_dat), .m_funct3_i(a_f3), .m_dat_o(a_mdat), .m_ack_o(a_ack),
    .m_err_o(a_err), .m_stall_o(a_stall),
    .s_cyc_o(a_scyc), .s_stb_o(a_sstb), .s_we_o(a_swe), .s_adr_o(a_sadr),
    .s_dat_o(a_sdat), .s_funct3_o(a_sf3), .s_dat_i(a_srdat), .s_ack_i(a_sack),
    .o_grant(a_grant)
  );

  mem_port_arbiter #(.NUM_MASTERS(4), .DATA_WIDTH(32), .ADDR_WIDTH(16),
                     .RR_MODE(1), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .rst(rst),
    .m_cyc_i(b_cyc), .m_stb_i(b_stb), .m_we_i(b_we), .m_adr_i(b_adr),
    .m_dat_i(b_dat), .m_funct3_i(b_f3), .m_dat_o(b_mdat), .m_ack_o(b_ack),
    .m_err_o(b_err), .m_stall_o(b_stall),
    .s_cyc_o(b_scyc), .s_stb_o(b_sstb), .s_we_o(b_swe), .s_adr_o(b_sadr),
    .s_dat_o(b_sdat), .s_funct3_o(b_sf3), .s_dat_i(b_srdat), .s_ack_i(b_sack),
    .o_grant(b_grant)
  );

  // mem_byte-like slaves: registered single-beat ack, registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) a_sack <= 1'b0;
    else     a_sack <= ack_en & a_scyc & a_sstb & ~a_sack;
  end
  always_ff @(posedge clk) begin
    if (a_scyc & a_sstb & ~a_sack) begin
      if (a_swe) mem[a_sadr[5:2]] <= a_sdat;
      a_srdat <= mem[a_sadr[5:2]];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) b_sack <= 1'b0;
    else     b_sack <= b_scyc & b_sstb & ~b_sack;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    a_cyc = 2'b10; a_stb = 2'b10; a_we = 2'b10;
    a_adr = {16'h0010, 16'h0000};
    a_dat = {32'hDEADBEEF, 32'h0};
    a_f3  = {3'b010, 3'b000};
    @(posedge clk); #1;
    vecs++; if (a_grant !== 2'b00) begin fails++; $display("FAIL rst_grant: got %b want 00", a_grant); end
    vecs++; if (a_scyc !== 1'b0 || a_sstb !== 1'b0) begin fails++; $display("FAIL rst_s_cyc_stb: got %b%b want 00", a_scyc, a_sstb); end
    vecs++; if (a_stall !== 2'b00) begin fails++; $display("FAIL rst_stall: got %b want 00", a_stall); end
    vecs++; if (a_ack !== 2'b00 || a_err !== 2'b00) begin fails++; $display("FAIL rst_ack_err: got %b/%b want 00/00", a_ack, a_err); end
    @(posedge clk); #1 rst = 1'b0;
    #1;
    vecs++; if (a_stall !== 2'b00) begin fails++; $display("FAIL first_idle_stall: got %b want 00", a_stall); end
    vecs++; if (a_grant !== 2'b00 || a_scyc !== 1'b0) begin fails++; $display("FAIL first_idle_grant: got %b/%b want 00/0", a_grant, a_scyc); end
  endtask

  task automatic test_single_master();
    step();
    vecs++; if (a_grant !== 2'b10) begin fails++; $display("FAIL single_grant: got %b want 10", a_grant); end
    vecs++; if (a_sadr !== 16'h0010) begin fails++; $display("FAIL single_s_adr: got %h want 0010", a_sadr); end
    vecs++; if (a_sdat !== 32'hDEADBEEF || a_swe !== 1'b1 || a_sf3 !== 3'b010) begin fails++; $display("FAIL single_s_wr: got %h/%b/%b want deadbeef/1/010", a_sdat, a_swe, a_sf3); end
    vecs++; if (a_ack !== 2'b00) begin fails++; $display("FAIL single_early_ack: got %b want 00", a_ack); end
    step();
    vecs++; if (a_ack !== 2'b10) begin fails++; $display("FAIL single_wr_ack: got %b want 10", a_ack); end
    a_cyc = 2'b00; a_stb = 2'b00; a_we = 2'b00;
    step();
    vecs++; if (a_grant !== 2'b00) begin fails++; $display("FAIL single_release: got %b want 00", a_grant); end
    a_cyc = 2'b10; a_stb = 2'b10;
    step();
    vecs++; if (a_grant !== 2'b10) begin fails++; $display("FAIL single_rd_grant: got %b want 10", a_grant); end
    step();
    vecs++; if (a_ack !== 2'b10) begin fails++; $display("FAIL single_rd_ack: got %b want 10", a_ack); end
    vecs++; if (a_mdat !== 32'hDEADBEEF) begin fails++; $display("FAIL single_rd_data: got %h want deadbeef", a_mdat); end
    a_cyc = 2'b00; a_stb = 2'b00;
    step();
  endtask

  task automatic test_fixed_priority();
    for (int it = 0; it < 3; it++) begin
      a_cyc = 2'b11; a_stb = 2'b11; a_we = 2'b00;
      a_adr = {16'h0004, 16'h0000};
      step();
      vecs++; if (a_grant !== 2'b01) begin fails++; $display("FAIL fixed_grant[%0d]: got %b want 01", it, a_grant); end
      vecs++; if (a_stall !== 2'b10) begin fails++; $display("FAIL fixed_stall[%0d]: got %b want 10", it, a_stall); end
      step();
      vecs++; if (a_ack !== 2'b01) begin fails++; $display("FAIL fixed_ack[%0d]: got %b want 01", it, a_ack); end
      vecs++; if (a_stall !== 2'b10) begin fails++; $display("FAIL fixed_stall_hold[%0d]: got %b want 10", it, a_stall); end
      a_cyc = 2'b00; a_stb = 2'b00;
      step();
      vecs++; if (a_grant !== 2'b00 || a_stall !== 2'b00) begin fails++; $display("FAIL fixed_withdraw[%0d]: got %b/%b want 00/00", it, a_grant, a_stall); end
    end
  endtask

  task automatic test_bus_lock();
    a_cyc = 2'b11; a_stb = 2'b11; a_we = 2'b01;
    a_adr = {16'h0040, 16'h0000};
    a_dat = {32'h0, 32'h100};
    step();
    vecs++; if (a_grant !== 2'b01) begin fails++; $display("FAIL lock_grant: got %b want 01", a_grant); end
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        step();
        vecs++; if (a_ack !== 2'b00) begin fails++; $display("FAIL lock_gap[%0d]: got %b want 00", b, a_ack); end
      end
      step();
      vecs++; if (a_ack !== 2'b01 || a_grant !== 2'b01) begin fails++; $display("FAIL lock_ack[%0d]: got %b/%b want 01/01", b, a_ack, a_grant); end
      vecs++; if (a_sadr !== 16'(b * 4) || a_sdat !== 32'h100 + 32'(b)) begin fails++; $display("FAIL lock_beat[%0d]: got %h/%h want %h/%h", b, a_sadr, a_sdat, 16'(b * 4), 32'h100 + 32'(b)); end
      vecs++; if (a_stall !== 2'b10) begin fails++; $display("FAIL lock_stall[%0d]: got %b want 10", b, a_stall); end
      a_adr[15:0] = 16'((b + 1) * 4);
      a_dat[31:0] = 32'h100 + 32'(b + 1);
    end
    a_cyc[0] = 1'b0; a_stb[0] = 1'b0; a_we = 2'b00;
    step();
    vecs++; if (a_grant !== 2'b00 || a_stall !== 2'b10) begin fails++; $display("FAIL lock_dead_cycle: got %b/%b want 00/10", a_grant, a_stall); end
    step();
    vecs++; if (a_grant !== 2'b10 || a_sadr !== 16'h0040) begin fails++; $display("FAIL lock_handover: got %b/%h want 10/0040", a_grant, a_sadr); end
    step();
    vecs++; if (a_ack !== 2'b10) begin fails++; $display("FAIL lock_m1_ack: got %b want 10", a_ack); end
    a_cyc = 2'b00; a_stb = 2'b00;
    step();
  endtask

  task automatic test_timeout();
    ack_en = 1'b0;
    a_cyc = 2'b01; a_stb = 2'b01; a_we = 2'b00;
    a_adr = 32'h0;
    step();
    vecs++; if (a_grant !== 2'b01 || a_sstb !== 1'b1) begin fails++; $display("FAIL tmo_grant: got %b/%b want 01/1", a_grant, a_sstb); end
    repeat (15) step();
    vecs++; if (a_err !== 2'b00 || a_sstb !== 1'b1) begin fails++; $display("FAIL tmo_early: got %b/%b want 00/1", a_err, a_sstb); end
    step();
    vecs++; if (a_err !== 2'b01) begin fails++; $display("FAIL tmo_err: got %b want 01", a_err); end
    vecs++; if (a_sstb !== 1'b0 || a_scyc !== 1'b0) begin fails++; $display("FAIL tmo_s_stb: got %b%b want 00", a_scyc, a_sstb); end
    step();
    vecs++; if (a_err !== 2'b00 || a_grant !== 2'b00) begin fails++; $display("FAIL tmo_to_idle: got %b/%b want 00/00", a_err, a_grant); end
    a_cyc = 2'b00; a_stb = 2'b00;
    ack_en = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    a_cyc = 2'b10; a_stb = 2'b10; a_we = 2'b10;
    a_adr = {16'h0020, 16'h0000};
    a_dat = {32'h12345678, 32'h0};
    step();
    vecs++; if (a_grant !== 2'b10 || a_sstb !== 1'b1) begin fails++; $display("FAIL mid_pre: got %b/%b want 10/1", a_grant, a_sstb); end
    #2 rst = 1'b1;
    #1;
    vecs++; if (a_scyc !== 1'b0 || a_sstb !== 1'b0) begin fails++; $display("FAIL mid_async_drop: got %b%b want 00", a_scyc, a_sstb); end
    vecs++; if (a_grant !== 2'b00 || a_stall !== 2'b00) begin fails++; $display("FAIL mid_grant: got %b/%b want 00/00", a_grant, a_stall); end
    @(posedge clk); #1 rst = 1'b0;
    #1;
    vecs++; if (a_stall !== 2'b00) begin fails++; $display("FAIL mid_first_idle: got %b want 00", a_stall); end
    step();
    vecs++; if (a_grant !== 2'b10 || a_sadr !== 16'h0020) begin fails++; $display("FAIL mid_regrant: got %b/%h want 10/0020", a_grant, a_sadr); end
    step();
    vecs++; if (a_ack !== 2'b10) begin fails++; $display("FAIL mid_ack: got %b want 10", a_ack); end
    a_cyc = 2'b00; a_stb = 2'b00; a_we = 2'b00;
    step();
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g;
    b_cyc = 4'hF; b_stb = 4'hF;
    for (int n = 0; n < 5; n++) begin
      exp_g = 4'b0001 << order[n];
      step();
      vecs++; if (b_grant !== exp_g) begin fails++; $display("FAIL rr_grant[%0d]: got %b want %b", n, b_grant, exp_g); end
      vecs++; if (b_stall !== (4'hF & ~exp_g)) begin fails++; $display("FAIL rr_stall[%0d]: got %b want %b", n, b_stall, 4'hF & ~exp_g); end
      step();
      vecs++; if (b_ack !== exp_g) begin fails++; $display("FAIL rr_ack[%0d]: got %b want %b", n, b_ack, exp_g); end
      b_cyc[order[n]] = 1'b0; b_stb[order[n]] = 1'b0;
      step();
      vecs++; if (b_grant !== 4'b0000) begin fails++; $display("FAIL rr_dead[%0d]: got %b want 0000", n, b_grant); end
      b_cyc[order[n]] = 1'b1; b_stb[order[n]] = 1'b1;
    end
    b_cyc = 4'h0; b_stb = 4'h0;
    step();
    vecs++; if (b_err !== 4'b0000) begin fails++; $display("FAIL rr_no_err: got %b want 0000", b_err); end
  endtask

  initial begin
    test_reset();
    test_single_master();
    test_fixed_priority();
    test_bus_lock();
    test_timeout();
    test_reset_mid();
    test_round_robin();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
